fft12_input_framer: RTL

- Streaming front end for the 12-point combinational FFT datapath.
- Accepts one complex 16-bit sample per cycle over a valid/ready handshake and assembles 12 consecutive samples into a frame.
- Presents each frame in parallel (x1..x12 real/imag) with its own valid/ready handshake.
- Ping-pong double buffer: a new frame can fill while the previous one waits for the consumer.

---
 rtl/fft12_pkg.sv | 22 ++
 rtl/fft12_frame_bank.sv | 91 +++++++++
 rtl/fft12_input_framer.sv | 103 ++++++++++
 3 files changed

// File: rtl/fft12_pkg.sv
// ============================================================================
// Module   : fft12_pkg
// Purpose  : Shared constants and sample/frame types for the 12-point FFT
//            input framer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fft12_pkg;

    localparam int N_PT   = 12;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    localparam logic [CNT_W-1:0] LAST_IDX = 4'd11;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef sample_t                  frame_t [N_PT];

endpackage

`default_nettype wire

// File: rtl/fft12_frame_bank.sv
// ============================================================================
// Module   : fft12_frame_bank
// Purpose  : One 12-entry re/im frame buffer with write index, full flag and
//            realignment pulse; instantiated twice as a ping-pong pair.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fft12_frame_bank #(
    parameter int DATA_W = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_en_i,
    input  logic                               first_i,
    input  logic                               clr_i,
    input  logic [DATA_W-1:0]                  din_re_i,
    input  logic [DATA_W-1:0]                  din_im_i,
    output logic                               full_o,
    output logic                               done_o,
    output logic                               align_o,
    output logic [fft12_pkg::N_PT*DATA_W-1:0]  frame_re_o,
    output logic [fft12_pkg::N_PT*DATA_W-1:0]  frame_im_o
);
    import fft12_pkg::*;

    logic [DATA_W-1:0] re_q [N_PT];
    logic [DATA_W-1:0] im_q [N_PT];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              full_q, full_d;
    logic              align_q;

    logic              w_realign;
    logic [CNT_W-1:0]  w_wr_idx;

    // A first-marked sample arriving mid-frame restarts the frame in place.
    assign w_realign = first_i && (cnt_q != '0);
    assign w_wr_idx  = w_realign ? '0 : cnt_q;
    assign done_o    = wr_en_i && !w_realign && (cnt_q == LAST_IDX);

    always_comb begin
        cnt_d  = cnt_q;
        full_d = full_q;
        if (wr_en_i) begin
            if (w_realign) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q == LAST_IDX) begin
                cnt_d  = '0;
                full_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (clr_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_PT; k++) begin
                re_q[k] <= '0;
                im_q[k] <= '0;
            end
            cnt_q   <= '0;
            full_q  <= 1'b0;
            align_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            align_q <= wr_en_i && w_realign;
            if (wr_en_i) begin
                re_q[w_wr_idx] <= din_re_i;
                im_q[w_wr_idx] <= din_im_i;
            end
        end
    end

    assign full_o  = full_q;
    assign align_o = align_q;

    generate
        for (genvar k = 0; k < N_PT; k++) begin : g_flat
            assign frame_re_o[DATA_W*k +: DATA_W] = re_q[k];
            assign frame_im_o[DATA_W*k +: DATA_W] = im_q[k];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/fft12_input_framer.sv
// ============================================================================
// Module   : fft12_input_framer
// Purpose  : Streaming sample-to-frame assembler with ping-pong buffering in
//            front of the 12-point FFT. FFT12_PRESCALE_EN enables the input
//            arithmetic right shift by PRESCALE_SHIFT.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fft12_input_framer #(
    parameter int DATA_W         = 16,
    parameter int PRESCALE_SHIFT = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               in_first,
    input  logic [DATA_W-1:0]                  in_re,
    input  logic [DATA_W-1:0]                  in_im,
    output logic                               frame_valid,
    input  logic                               frame_ready,
    output logic [fft12_pkg::N_PT*DATA_W-1:0]  frame_re,
    output logic [fft12_pkg::N_PT*DATA_W-1:0]  frame_im,
    output logic                               align_err
);
    import fft12_pkg::*;

    logic                       wr_sel_q, wr_sel_d;
    logic                       rd_sel_q, rd_sel_d;

    logic [1:0]                 w_full;
    logic [1:0]                 w_done;
    logic [1:0]                 w_align;
    logic [1:0]                 w_wr_en;
    logic [1:0]                 w_clr;
    logic                       w_accept;
    logic                       w_consume;
    logic [DATA_W-1:0]          w_re;
    logic [DATA_W-1:0]          w_im;
    logic [N_PT*DATA_W-1:0]     w_bank_re [2];
    logic [N_PT*DATA_W-1:0]     w_bank_im [2];

`ifdef FFT12_PRESCALE_EN
    assign w_re = $signed(in_re) >>> PRESCALE_SHIFT;
    assign w_im = $signed(in_im) >>> PRESCALE_SHIFT;
`else
    assign w_re = in_re;
    assign w_im = in_im;
`endif

    assign in_ready    = !rst && !w_full[wr_sel_q];
    assign w_accept    = in_valid && in_ready;
    assign frame_valid = w_full[rd_sel_q];
    assign w_consume   = frame_valid && frame_ready;

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            assign w_wr_en[b] = w_accept  && (wr_sel_q == 1'(b));
            assign w_clr[b]   = w_consume && (rd_sel_q == 1'(b));

            fft12_frame_bank #(
                .DATA_W (DATA_W)
            ) u_bank (
                .clk        (clk),
                .rst        (rst),
                .wr_en_i    (w_wr_en[b]),
                .first_i    (in_first),
                .clr_i      (w_clr[b]),
                .din_re_i   (w_re),
                .din_im_i   (w_im),
                .full_o     (w_full[b]),
                .done_o     (w_done[b]),
                .align_o    (w_align[b]),
                .frame_re_o (w_bank_re[b]),
                .frame_im_o (w_bank_im[b])
            );
        end
    endgenerate

    always_comb begin
        wr_sel_d = wr_sel_q ^ w_done[wr_sel_q];
        rd_sel_d = rd_sel_q ^ w_consume;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    // Output comes straight from bank registers, so it holds while stalled.
    assign frame_re  = rd_sel_q ? w_bank_re[1] : w_bank_re[0];
    assign frame_im  = rd_sel_q ? w_bank_im[1] : w_bank_im[0];
    assign align_err = |w_align;

endmodule

`default_nettype wire
